// File: rtl/hpdcache_wb_fence_ctrl_pkg.sv
// Shared types for the write-back HPDcache fence sequencer.
// CMO opcodes and the fence sequence states.
package hpdcache_wb_fence_ctrl_pkg;

  typedef enum logic [1:0] {
    FLUSH_ALL       = 2'd0,
    FLUSH_INVAL_ALL = 2'd1
  } cmo_op_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    CMO_REQ  = 3'd2,
    CMO_WAIT = 3'd3,
    ICACHE   = 3'd4,
    DONE     = 3'd5
  } fence_state_e;

endpackage

// File: rtl/hpdcache_wb_fence_ctrl.sv
// FENCE / FENCE.I sequencer: drain stores, flush dcache,
// optionally flush icache, then ack the controller.
module hpdcache_wb_fence_ctrl
  import hpdcache_wb_fence_ctrl_pkg::*;
#(
  parameter logic        FlushOnFence      = 1'b1,
  parameter logic        InvalidateOnFlush = 1'b0,
  parameter int unsigned CntWidth          = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fence_req_i,
  input  logic                fence_i_i,
  input  logic                stb_empty_i,
  output logic                cmo_req_valid_o,
  input  logic                cmo_req_ready_i,
  output logic [1:0]          cmo_req_op_o,
  input  logic                cmo_rsp_valid_i,
  output logic                icache_flush_o,
  output logic                fence_ack_o,
  output logic                busy_o,
  output logic [CntWidth-1:0] last_cycles_o
);

  localparam cmo_op_t FlushOp =
    InvalidateOnFlush ? FLUSH_INVAL_ALL : FLUSH_ALL;

  fence_state_e        state_q, state_d;
  logic                is_fi_q;
  logic                start;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_inc;
  logic [CntWidth-1:0] last_q;

  // Saturating increment, shared by the counter and the snapshot
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      is_fi_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        is_fi_q <= fence_i_i;
        cnt_q   <= '0;
      end else if (state_q != IDLE) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == DONE) begin
        last_q <= cnt_inc;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    start           = 1'b0;
    cmo_req_valid_o = 1'b0;
    icache_flush_o  = 1'b0;
    fence_ack_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fence_req_i) begin
          start   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (stb_empty_i) begin
          state_d = (is_fi_q || FlushOnFence) ? CMO_REQ : DONE;
        end
      end
      CMO_REQ: begin
        cmo_req_valid_o = 1'b1;
        if (cmo_req_ready_i) begin
          state_d = CMO_WAIT;
        end
      end
      CMO_WAIT: begin
        if (cmo_rsp_valid_i) begin
          state_d = is_fi_q ? ICACHE : DONE;
        end
      end
      ICACHE: begin
        icache_flush_o = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        fence_ack_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmo_req_op_o  = cmo_req_valid_o ? FlushOp : FLUSH_ALL;
  assign busy_o        = (state_q != IDLE);
  assign last_cycles_o = last_q;

endmodule

// File: tb/tb_hpdcache_wb_fence_ctrl.sv
// Directed bench for the fence sequencer, three parameter sets
// sharing one stimulus bus.
module tb_hpdcache_wb_fence_ctrl;

  logic clk;
  logic rst_n;
  logic req;
  logic fi;
  logic stb;
  logic rdy;
  logic rsp;

  logic        a_valid, a_icf, a_ack, a_busy;
  logic [1:0]  a_op;
  logic [3:0]  a_last;
  logic        b_valid, b_icf, b_ack, b_busy;
  logic [1:0]  b_op;
  logic [15:0] b_last;
  logic        c_valid, c_icf, c_ack, c_busy;
  logic [1:0]  c_op;
  logic [15:0] c_last;

  int total = 0;
  int bad   = 0;
  int b_acks = 0;
  int b_icfs = 0;
  int b_cmos = 0;

  // A: drain-only fence, 4-bit counter
  hpdcache_wb_fence_ctrl #(
    .FlushOnFence(1'b0), .InvalidateOnFlush(1'b0), .CntWidth(4)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .fence_req_i(req),
    .fence_i_i(fi), .stb_empty_i(stb),
    .cmo_req_valid_o(a_valid), .cmo_req_ready_i(rdy),
    .cmo_req_op_o(a_op), .cmo_rsp_valid_i(rsp),
    .icache_flush_o(a_icf), .fence_ack_o(a_ack),
    .busy_o(a_busy), .last_cycles_o(a_last)
  );

  // B: default parameters
  hpdcache_wb_fence_ctrl u_b (
    .clk_i(clk), .rst_ni(rst_n), .fence_req_i(req),
    .fence_i_i(fi), .stb_empty_i(stb),
    .cmo_req_valid_o(b_valid), .cmo_req_ready_i(rdy),
    .cmo_req_op_o(b_op), .cmo_rsp_valid_i(rsp),
    .icache_flush_o(b_icf), .fence_ack_o(b_ack),
    .busy_o(b_busy), .last_cycles_o(b_last)
  );

  // C: flush with invalidate
  hpdcache_wb_fence_ctrl #(
    .FlushOnFence(1'b1), .InvalidateOnFlush(1'b1), .CntWidth(16)
  ) u_c (
    .clk_i(clk), .rst_ni(rst_n), .fence_req_i(req),
    .fence_i_i(fi), .stb_empty_i(stb),
    .cmo_req_valid_o(c_valid), .cmo_req_ready_i(rdy),
    .cmo_req_op_o(c_op), .cmo_rsp_valid_i(rsp),
    .icache_flush_o(c_icf), .fence_ack_o(c_ack),
    .busy_o(c_busy), .last_cycles_o(c_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b_ack) b_acks <= b_acks + 1;
    if (b_icf) b_icfs <= b_icfs + 1;
    if (b_valid && rdy) b_cmos <= b_cmos + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = 1'b0; fi = 1'b0; stb = 1'b0;
    rdy = 1'b0; rsp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int ack0, icf0, cmo0;
  int seen;

  initial begin
    rst_n = 1'b0;
    req = 1'b0; fi = 1'b0; stb = 1'b0;
    rdy = 1'b0; rsp = 1'b0;

    // reset state
    mid;
    chk("rst_a_busy", 32'(a_busy), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_b_ack", 32'(b_ack), 0);
    chk("rst_c_icf", 32'(c_icf), 0);
    chk("rst_b_last", 32'(b_last), 0);
    do_reset;

    // 1: minimum-latency plain fence on A
    req = 1'b1; fi = 1'b0; stb = 1'b1;
    mid;
    chk("t1_c0_busy", 32'(a_busy), 0);
    chk("t1_c0_ack", 32'(a_ack), 0);
    step; mid;
    chk("t1_c1_busy", 32'(a_busy), 1);
    chk("t1_c1_ack", 32'(a_ack), 0);
    step; mid;
    chk("t1_c2_ack", 32'(a_ack), 1);
    chk("t1_c2_valid", 32'(a_valid), 0);
    req = 1'b0;
    step; mid;
    chk("t1_last", 32'(a_last), 2);
    chk("t1_idle", 32'(a_busy), 0);

    // 2: plain fence with flush on B, slow drain and response
    do_reset;
    req = 1'b1; fi = 1'b0; stb = 1'b0; rdy = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      mid;
      if (b_valid) seen++;
      step;
    end
    stb = 1'b1;
    mid;
    chk("t2_c5_valid", 32'(b_valid), 0);
    chk("t2_drain_valid", 32'(seen), 0);
    step; mid;
    chk("t2_c6_valid", 32'(b_valid), 1);
    chk("t2_c6_op", 32'(b_op), 0);
    step;
    rdy = 1'b0;
    ack0 = b_acks; icf0 = b_icfs;
    mid;
    chk("t2_c7_valid", 32'(b_valid), 0);
    chk("t2_c7_busy", 32'(b_busy), 1);
    for (int i = 7; i < 16; i++) step;
    rsp = 1'b1;
    step;
    rsp = 1'b0;
    mid;
    chk("t2_c17_ack", 32'(b_ack), 1);
    req = 1'b0;
    step; mid;
    chk("t2_c18_busy", 32'(b_busy), 0);
    chk("t2_last", 32'(b_last), 17);
    step;
    chk("t2_acks", 32'(b_acks - ack0), 1);
    chk("t2_icf", 32'(b_icfs - icf0), 0);

    // 3: FENCE.I with invalidate on C, ready held off
    do_reset;
    req = 1'b1; fi = 1'b1; stb = 1'b1; rdy = 1'b0;
    mid;
    step; mid;
    chk("t3_c1_valid", 32'(c_valid), 0);
    chk("t3_c1_busy", 32'(c_busy), 1);
    step;
    for (int i = 0; i < 4; i++) begin
      rdy = (i == 3);
      mid;
      chk($sformatf("t3_valid_%0d", i), 32'(c_valid), 1);
      chk($sformatf("t3_op_%0d", i), 32'(c_op), 1);
      step;
    end
    rdy = 1'b0;
    mid;
    chk("t3_c6_valid", 32'(c_valid), 0);
    step;
    rsp = 1'b1;
    mid;
    chk("t3_c7_icf", 32'(c_icf), 0);
    step;
    rsp = 1'b0;
    mid;
    chk("t3_c8_icf", 32'(c_icf), 1);
    chk("t3_c8_ack", 32'(c_ack), 0);
    step; mid;
    chk("t3_c9_ack", 32'(c_ack), 1);
    chk("t3_c9_icf", 32'(c_icf), 0);
    req = 1'b0;
    step; mid;
    chk("t3_last", 32'(c_last), 9);
    chk("t3_idle", 32'(c_busy), 0);

    // 4: back-to-back FENCE.I on B
    do_reset;
    req = 1'b1; fi = 1'b1; stb = 1'b1; rdy = 1'b1;
    ack0 = b_acks; icf0 = b_icfs; cmo0 = b_cmos;
    for (int i = 0; i < 12; i++) begin
      rsp = (i == 3) || (i == 9);
      mid;
      chk($sformatf("t4_ack_%0d", i), 32'(b_ack),
          32'((i == 5) || (i == 11)));
      chk($sformatf("t4_icf_%0d", i), 32'(b_icf),
          32'((i == 4) || (i == 10)));
      if (i == 6) chk("t4_gap_busy", 32'(b_busy), 0);
      if (i == 11) req = 1'b0;
      step;
    end
    rsp = 1'b0;
    mid;
    chk("t4_end_busy", 32'(b_busy), 0);
    step;
    chk("t4_acks", 32'(b_acks - ack0), 2);
    chk("t4_icfs", 32'(b_icfs - icf0), 2);
    chk("t4_cmos", 32'(b_cmos - cmo0), 2);

    // 5: async reset during CMO_WAIT on B, then a clean fence
    do_reset;
    req = 1'b1; fi = 1'b0; stb = 1'b1; rdy = 1'b1;
    step; step; mid;
    chk("t5_c2_valid", 32'(b_valid), 1);
    step; mid;
    chk("t5_c3_busy", 32'(b_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 32'(b_busy), 0);
    chk("t5_async_valid", 32'(b_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mid;
    chk("t5_r_busy", 32'(b_busy), 0);
    chk("t5_r_last", 32'(b_last), 0);
    step; step; mid;
    chk("t5_r_valid", 32'(b_valid), 1);
    step;
    rsp = 1'b1;
    step;
    rsp = 1'b0;
    mid;
    chk("t5_r_ack", 32'(b_ack), 1);
    req = 1'b0;
    step; mid;
    chk("t5_r_last4", 32'(b_last), 4);

    // 6: counter saturation on A
    do_reset;
    mid;
    chk("t6_rst_last", 32'(a_last), 0);
    req = 1'b1; fi = 1'b0; stb = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 20; i++) step;
    stb = 1'b1;
    step; mid;
    chk("t6_c21_ack", 32'(a_ack), 1);
    chk("t6_c21_valid", 32'(a_valid), 0);
    req = 1'b0;
    step; mid;
    chk("t6_last_sat", 32'(a_last), 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
